sram_responder: RTL

Synthesizable responder for the processor's external SRAM bus (64-bit bidirectional data, 17-bit address, active-low write strobe). It is the device end of the interface driven by the memory stage's SRAM controller. It models an asynchronous SRAM with a fixed access latency and a tristate data return, and it counts completed transactions for verification. It sits outside the processor top in simulation and FPGA bring-up builds.

---
 rtl/sram_responder_pkg.sv | 21 ++
 rtl/sram_rsp_array.sv | 32 +++
 rtl/sram_responder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/sram_responder_pkg.sv
// Shared definitions for the external SRAM bus responder: state encodings and default geometry.
package sram_responder_pkg;

  localparam int unsigned SRAM_ADDR_W_DEF      = 17;
  localparam int unsigned SRAM_DATA_W_DEF      = 64;
  localparam int unsigned SRAM_WAIT_STATES_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_HOLD = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_WR_DONE = 3'd4
  } state_t;

  // True while an access is still counting down and can be abandoned.
  function automatic logic is_wait(state_t s);
    return (s == ST_RD_WAIT) || (s == ST_WR_WAIT);
  endfunction

endpackage

// File: rtl/sram_rsp_array.sv
// Word array for the SRAM responder: one synchronous write port, one registered read port.
// Array contents survive reset; only the read register is cleared.
module sram_rsp_array
  import sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = SRAM_ADDR_W_DEF,
  parameter int unsigned DATA_W = SRAM_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sram_responder.sv
// Device end of the external SRAM bus: fixed-latency async SRAM model with tristate read return.
// Optional build macro SRAM_RSP_ABORT_CHECK_EN adds the saturating abort counter.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = SRAM_ADDR_W_DEF,
  parameter int unsigned DATA_W      = SRAM_DATA_W_DEF,
  parameter int unsigned WAIT_STATES = SRAM_WAIT_STATES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_WE_N,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt,
  output logic [7:0]        abort_cnt
);

  localparam int unsigned CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_n_q;
  logic              access_start;
  logic              mem_we, mem_re;
  logic [DATA_W-1:0] rd_data_q;

  // IDLE only exists straight after reset, so the first live edge always opens an access.
  assign access_start = (state == ST_IDLE) || (SRAM_ADDR != addr_q) || (SRAM_WE_N != we_n_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      addr_q <= '0;
      we_n_q <= 1'b1;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      addr_q <= SRAM_ADDR;
      we_n_q <= SRAM_WE_N;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    if (access_start) begin
      cnt_d   = CNT_W'(WAIT_STATES - 1);
      state_d = SRAM_WE_N ? ST_RD_WAIT : ST_WR_WAIT;
    end else begin
      case (state)
        ST_RD_WAIT: begin
          if (cnt == '0) begin
            mem_re  = 1'b1;
            state_d = ST_RD_HOLD;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
        ST_WR_WAIT: begin
          if (cnt == '0) begin
            mem_we  = 1'b1;
            state_d = ST_WR_DONE;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
    // Reset wins: a write due on the reset edge must never reach the array.
    if (rst) begin
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  sram_rsp_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (addr_q),
    .wdata (SRAM_DQ),
    .re    (mem_re),
    .raddr (addr_q),
    .rdata (rd_data_q)
  );

  // Drive only after two consecutive read samples so the turnaround edge never contends.
  assign SRAM_DQ = (SRAM_WE_N & we_n_q & ~rst) ? rd_data_q : {DATA_W{1'bz}};

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (mem_re) rd_cnt <= rd_cnt + 16'd1;
      if (mem_we) wr_cnt <= wr_cnt + 16'd1;
    end
  end

`ifdef SRAM_RSP_ABORT_CHECK_EN
  logic abort;
  assign abort = access_start & is_wait(state);

  always_ff @(posedge clk) begin
    if (rst)                             abort_cnt <= '0;
    else if (abort && abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
  end
`else
  assign abort_cnt = '0;
`endif

endmodule
